tile_flush_scheduler: RTL and testbench

Frame-level sequencer for the tile write-back path. It walks the framebuffer tile by tile (16×32 px, 32-bit pixels; 64 B × 32 rows), hands the current tile coordinate to the rasterizer, and starts the tile writer once the tile RAM is filled. It releases the tile RAM back to the rasterizer when the writer finishes reading, and reports frame completion once the writer FIFO has fully drained. It sits in the gpu_clk domain between the rasterizer's tile RAM producer and the tile writer.

---
 rtl/tile_sched_pkg.sv | 24 ++
 rtl/tile_addr_gen.sv | 58 +++++
 rtl/tile_flush_scheduler.sv | 151 +++++++++++++++
 tb/tb_tile_flush_scheduler.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_sched_pkg.sv
// Shared types and constants for the tile flush scheduler: FSM state encoding,
// tile geometry (64 B x 32 rows) and the default coordinate width.
package tile_sched_pkg;

    localparam int COORD_W_DEFAULT = 8;
    localparam int TILE_ROW_BYTES  = 64;
    localparam int TILE_ROWS_LOG2  = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TILE,
        S_START,
        S_DRAIN,
        S_FLUSH,
        S_DONE
    } sched_state_e;

    // Byte distance between vertically adjacent tiles; the shifted stride is
    // widened to 32 bits first so the add wraps modulo 2^32.
    function automatic logic [31:0] tile_row_step(input logic [15:0] stride);
        return {16'd0, stride} << TILE_ROWS_LOG2;
    endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// Tile walker: row-major tile coordinates plus the matching framebuffer byte
// address of the current tile, with a flag marking the final tile of the frame.
module tile_addr_gen
    import tile_sched_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic               advance,
    input  logic [31:0]        fb_base,
    input  logic [15:0]        fb_stride,
    input  logic [COORD_W-1:0] tiles_x,
    input  logic [COORD_W-1:0] tiles_y,
    output logic [COORD_W-1:0] tile_x,
    output logic [COORD_W-1:0] tile_y,
    output logic [31:0]        addr,
    output logic               last
);

    logic [31:0] row_base;
    logic [31:0] next_row_base;
    logic        row_end;

    assign row_end       = (tile_x == tiles_x - COORD_W'(1));
    assign last          = row_end && (tile_y == tiles_y - COORD_W'(1));
    assign next_row_base = row_base + tile_row_step(fb_stride);

    // The final tile does not move the walker; coordinates stay put until the
    // next frame is initialised.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            tile_x   <= '0;
            tile_y   <= '0;
            row_base <= '0;
            addr     <= '0;
        end else if (init) begin
            tile_x   <= '0;
            tile_y   <= '0;
            row_base <= fb_base;
            addr     <= fb_base;
        end else if (advance && !last) begin
            if (row_end) begin
                tile_x   <= '0;
                tile_y   <= tile_y + COORD_W'(1);
                row_base <= next_row_base;
                addr     <= next_row_base;
            end else begin
                tile_x <= tile_x + COORD_W'(1);
                addr   <= addr + 32'(TILE_ROW_BYTES);
            end
        end
    end

endmodule

// File: rtl/tile_flush_scheduler.sv
// Frame sequencer for the tile write-back path: walks tiles, starts the writer,
// recycles the tile RAM and reports frame completion once the writer drains.
// Optional TILE_SCHED_PERF_EN adds wait/drain cycle counters.
module tile_flush_scheduler
    import tile_sched_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEFAULT
) (
    input  logic               gpu_clk,
    input  logic               gpu_rst,
    input  logic               frame_start,
    input  logic [31:0]        fb_base,
    input  logic [15:0]        fb_stride,
    input  logic [COORD_W-1:0] tiles_x,
    input  logic [COORD_W-1:0] tiles_y,
    output logic               busy,
    output logic               frame_done,
    output logic [COORD_W-1:0] tile_x,
    output logic [COORD_W-1:0] tile_y,
    input  logic               tile_valid,
    output logic               tile_ready,
    output logic               writer_start,
    output logic [31:0]        writer_addr,
    output logic [15:0]        writer_stride,
    input  logic               writer_reading,
    input  logic               writer_flushed
`ifdef TILE_SCHED_PERF_EN
    ,
    output logic [31:0]        perf_wait_cycles,
    output logic [31:0]        perf_drain_cycles
`endif
);

    sched_state_e state, next_state;

    logic               accept;
    logic               init;
    logic               drain_done;
    logic               drain_first;
    logic               empty_frame;
    logic               last_tile;
    logic [COORD_W-1:0] tiles_x_q;
    logic [COORD_W-1:0] tiles_y_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves a value unassigned (which would infer a latch).
        next_state = state;
        accept     = 1'b0;
        init       = 1'b0;
        drain_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (frame_start) begin
                    accept = 1'b1;
                    if (tiles_x == '0 || tiles_y == '0) begin
                        next_state = S_DONE;
                    end else begin
                        init       = 1'b1;
                        next_state = S_WAIT_TILE;
                    end
                end
            end
            S_WAIT_TILE: begin
                if (tile_valid) next_state = S_START;
            end
            S_START: next_state = S_DRAIN;
            S_DRAIN: begin
                // The writer raises writer_reading one cycle after start, so the
                // first drain cycle must not treat a low level as "done".
                if (!drain_first && !writer_reading) begin
                    drain_done = 1'b1;
                    next_state = last_tile ? S_FLUSH : S_WAIT_TILE;
                end
            end
            S_FLUSH: begin
                if (writer_flushed) next_state = S_DONE;
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Outputs are flops decoded from the next state so they align with it.
    always_ff @(posedge gpu_clk) begin
        if (gpu_rst) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            tile_ready    <= 1'b0;
            writer_start  <= 1'b0;
            writer_stride <= '0;
            drain_first   <= 1'b0;
            empty_frame   <= 1'b0;
            tiles_x_q     <= '0;
            tiles_y_q     <= '0;
        end else begin
            state        <= next_state;
            busy         <= (next_state != S_IDLE);
            writer_start <= (next_state == S_START);
            tile_ready   <= drain_done;
            drain_first  <= (state == S_START);
            // A flushed frame reports in its S_DONE cycle; an empty frame passes
            // through S_DONE first and reports on the cycle after it.
            frame_done   <= (state == S_FLUSH && writer_flushed) ||
                            (state == S_DONE && empty_frame);
            if (accept) begin
                empty_frame <= (tiles_x == '0 || tiles_y == '0);
            end
            if (init) begin
                tiles_x_q     <= tiles_x;
                tiles_y_q     <= tiles_y;
                writer_stride <= fb_stride;
            end
        end
    end

    tile_addr_gen #(
        .COORD_W (COORD_W)
    ) u_addr_gen (
        .clk       (gpu_clk),
        .rst       (gpu_rst),
        .init      (init),
        .advance   (drain_done),
        .fb_base   (fb_base),
        .fb_stride (writer_stride),
        .tiles_x   (tiles_x_q),
        .tiles_y   (tiles_y_q),
        .tile_x    (tile_x),
        .tile_y    (tile_y),
        .addr      (writer_addr),
        .last      (last_tile)
    );

`ifdef TILE_SCHED_PERF_EN
    always_ff @(posedge gpu_clk) begin
        if (gpu_rst || accept) begin
            perf_wait_cycles  <= '0;
            perf_drain_cycles <= '0;
        end else begin
            if (state == S_WAIT_TILE && perf_wait_cycles != '1) begin
                perf_wait_cycles <= perf_wait_cycles + 32'd1;
            end
            if ((state == S_DRAIN || state == S_FLUSH) && perf_drain_cycles != '1) begin
                perf_drain_cycles <= perf_drain_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tile_flush_scheduler.sv
// Self-checking bench for tile_flush_scheduler: directed and randomized frames
// compared every cycle against a frame-walk reference model.
module tb_tile_flush_scheduler;
    import tile_sched_pkg::*;

    localparam int CW = COORD_W_DEFAULT;

    logic          gpu_clk        = 1'b0;
    logic          gpu_rst        = 1'b1;
    logic          frame_start    = 1'b0;
    logic [31:0]   fb_base        = '0;
    logic [15:0]   fb_stride      = '0;
    logic [CW-1:0] tiles_x        = '0;
    logic [CW-1:0] tiles_y        = '0;
    logic          tile_valid     = 1'b0;
    logic          writer_reading = 1'b0;
    logic          writer_flushed = 1'b1;
    logic          busy, frame_done, tile_ready, writer_start;
    logic [CW-1:0] tile_x, tile_y;
    logic [31:0]   writer_addr;
    logic [15:0]   writer_stride;
`ifdef TILE_SCHED_PERF_EN
    logic [31:0]   perf_wait_cycles, perf_drain_cycles;
`endif

    tile_flush_scheduler #(.COORD_W(CW)) dut (
        .gpu_clk           (gpu_clk),
        .gpu_rst           (gpu_rst),
        .frame_start       (frame_start),
        .fb_base           (fb_base),
        .fb_stride         (fb_stride),
        .tiles_x           (tiles_x),
        .tiles_y           (tiles_y),
        .busy              (busy),
        .frame_done        (frame_done),
        .tile_x            (tile_x),
        .tile_y            (tile_y),
        .tile_valid        (tile_valid),
        .tile_ready        (tile_ready),
        .writer_start      (writer_start),
        .writer_addr       (writer_addr),
        .writer_stride     (writer_stride),
        .writer_reading    (writer_reading),
        .writer_flushed    (writer_flushed)
`ifdef TILE_SCHED_PERF_EN
        ,
        .perf_wait_cycles  (perf_wait_cycles),
        .perf_drain_cycles (perf_drain_cycles)
`endif
    );

    always #5 gpu_clk = ~gpu_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: frame walk by tile index ----------------
    typedef enum int {P_IDLE, P_EMPTY, P_WAIT, P_START, P_DRAIN0, P_DRAIN, P_FLUSH, P_DONE} phase_e;

    phase_e      ph       = P_IDLE;
    int          m_tx     = 0;
    int          m_ty     = 0;
    int          m_k      = 0;
    logic [31:0] m_base   = '0;
    logic        e_busy   = 1'b0;
    logic        e_fd     = 1'b0;
    logic        e_tr     = 1'b0;
    logic        e_ws     = 1'b0;
    int          e_x      = 0;
    int          e_y      = 0;
    logic [31:0] e_addr   = '0;
    logic [15:0] e_stride = '0;
    logic [31:0] m_wait   = '0;
    logic [31:0] m_drain  = '0;

    function automatic logic [31:0] exp_addr(input logic [31:0] base, input logic [15:0] stride,
                                             input int k, input int tx);
        logic [31:0] x, y;
        x = 32'(k % tx);
        y = 32'(k / tx);
        return base + y * ({16'd0, stride} * 32'd32) + x * 32'd64;
    endfunction

    always @(posedge gpu_clk) begin
        e_ws = 1'b0;
        e_tr = 1'b0;
        e_fd = 1'b0;
        if (gpu_rst) begin
            ph = P_IDLE; e_x = 0; e_y = 0; e_addr = '0; e_stride = '0;
            m_wait = '0; m_drain = '0;
        end else begin
            if (ph == P_IDLE && frame_start) begin
                m_wait = '0; m_drain = '0;
            end else begin
                if (ph == P_WAIT && m_wait != 32'hFFFF_FFFF) m_wait = m_wait + 1;
                if ((ph == P_DRAIN0 || ph == P_DRAIN || ph == P_FLUSH) && m_drain != 32'hFFFF_FFFF)
                    m_drain = m_drain + 1;
            end
            case (ph)
                P_IDLE: if (frame_start) begin
                    if (tiles_x == 0 || tiles_y == 0) ph = P_EMPTY;
                    else begin
                        m_tx = int'(tiles_x); m_ty = int'(tiles_y); m_base = fb_base;
                        e_stride = fb_stride; m_k = 0; e_x = 0; e_y = 0; e_addr = fb_base;
                        ph = P_WAIT;
                    end
                end
                P_EMPTY: begin e_fd = 1'b1; ph = P_IDLE; end
                P_WAIT:  if (tile_valid) begin e_ws = 1'b1; ph = P_START; end
                P_START: ph = P_DRAIN0;
                P_DRAIN0: ph = P_DRAIN;
                P_DRAIN: if (!writer_reading) begin
                    e_tr = 1'b1;
                    if (m_k == m_tx * m_ty - 1) ph = P_FLUSH;
                    else begin
                        m_k++;
                        e_x = m_k % m_tx; e_y = m_k / m_tx;
                        e_addr = exp_addr(m_base, e_stride, m_k, m_tx);
                        ph = P_WAIT;
                    end
                end
                P_FLUSH: if (writer_flushed) begin e_fd = 1'b1; ph = P_DONE; end
                P_DONE:  ph = P_IDLE;
                default: ph = P_IDLE;
            endcase
        end
        e_busy = (ph != P_IDLE);
    end

    // ---------------- per-cycle compare ----------------
    bit started  = 1'b0;
    int ws_count = 0;
    int tr_count = 0;

    always @(negedge gpu_clk) begin
        if (started) begin
            check("busy", 32'(busy), 32'(e_busy));
            check("frame_done", 32'(frame_done), 32'(e_fd));
            check("tile_ready", 32'(tile_ready), 32'(e_tr));
            check("writer_start", 32'(writer_start), 32'(e_ws));
            check("tile_x", 32'(tile_x), 32'(e_x));
            check("tile_y", 32'(tile_y), 32'(e_y));
            check("writer_addr", writer_addr, e_addr);
            check("writer_stride", 32'(writer_stride), 32'(e_stride));
`ifdef TILE_SCHED_PERF_EN
            check("perf_wait_cycles", perf_wait_cycles, m_wait);
            check("perf_drain_cycles", perf_drain_cycles, m_drain);
`endif
            if (writer_start) ws_count++;
            if (tile_ready) tr_count++;
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] addr_log[$];
    int          cx_log[$];
    int          cy_log[$];

    task automatic step();
        @(posedge gpu_clk);
        #1;
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return writer_start;
            1:       return tile_ready;
            default: return frame_done;
        endcase
    endfunction

    task automatic wait_out(input int which, input int budget, input string name, output int n);
        n = 0;
        while (!sel(which) && n < budget) begin
            step();
            n++;
        end
        check({name, " seen"}, 32'(sel(which)), 32'd1);
    endtask

    task automatic run_frame(input logic [31:0] base, input logic [15:0] stride,
                             input int tx, input int ty, input int dmin, input int dmax,
                             input int lmin, input int lmax, input int flush_hold,
                             input bit hold_valid, input bit poke_start,
                             output int n_ready, output int done_lat);
        int d, l, n, tr0;
        fb_base = base; fb_stride = stride;
        tiles_x = CW'(tx); tiles_y = CW'(ty);
        addr_log.delete(); cx_log.delete(); cy_log.delete();
        tr0 = tr_count;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        if (tx == 0 || ty == 0) begin
            done_lat = 1;
            while (!frame_done && done_lat < 20) begin step(); done_lat++; end
            n_ready = tr_count - tr0;
            step();
            return;
        end
        for (int k = 0; k < tx * ty; k++) begin
            d = int'($urandom_range(dmax, dmin));
            l = int'($urandom_range(lmax, lmin));
            if (!(hold_valid && tile_valid)) begin
                repeat (d - 1) step();
                tile_valid = 1'b1;
            end
            wait_out(0, 200, "writer_start", n);
            addr_log.push_back(writer_addr);
            cx_log.push_back(int'(tile_x));
            cy_log.push_back(int'(tile_y));
            if (!hold_valid) tile_valid = 1'b0;
            if (poke_start && k == 0) frame_start = 1'b1;
            step();
            frame_start = 1'b0;
            writer_reading = 1'b1;
            writer_flushed = 1'b0;
            repeat (l) step();
            writer_reading = 1'b0;
            wait_out(1, 10, "tile_ready", n);
        end
        tile_valid = 1'b0;
        repeat (flush_hold) step();
        writer_flushed = 1'b1;
        done_lat = 0;
        while (!frame_done && done_lat < 300) begin step(); done_lat++; end
        check("frame_done seen", 32'(frame_done), 32'd1);
        n_ready = tr_count - tr0;
        step();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int nr, dl, ws0, fd_seen, n;
        logic [31:0] exp3x2[6];
        logic [31:0] rbase;

        @(posedge gpu_clk);
        #1;
        started = 1'b1;
        step();
        check("reset busy", 32'(busy), 32'd0);
        check("reset writer_addr", writer_addr, 32'd0);
        check("reset tile_x", 32'(tile_x), 32'd0);
        gpu_rst = 1'b0;
        step();

        // Single tile, writer releases 512 cycles after start
        run_frame(32'h1000_0000, 16'h0A00, 1, 1, 2, 2, 511, 511, 3, 1'b0, 1'b0, nr, dl);
        check("single addr count", 32'(addr_log.size()), 32'd1);
        check("single addr", addr_log[0], 32'h1000_0000);
        check("single tile_ready count", 32'(nr), 32'd1);
        check("single flushed->done latency", 32'(dl), 32'd1);

        // 3x2 frame: row-major walk and address sequence
        exp3x2 = '{32'h2000_0000, 32'h2000_0040, 32'h2000_0080,
                   32'h2001_8000, 32'h2001_8040, 32'h2001_8080};
        run_frame(32'h2000_0000, 16'h0C00, 3, 2, 1, 4, 1, 6, 2, 1'b0, 1'b0, nr, dl);
        check("3x2 tile_ready count", 32'(nr), 32'd6);
        check("3x2 addr count", 32'(addr_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < addr_log.size(); i++) begin
            check($sformatf("3x2 addr[%0d]", i), addr_log[i], exp3x2[i]);
            check($sformatf("3x2 tile_x[%0d]", i), 32'(cx_log[i]), 32'(i % 3));
            check($sformatf("3x2 tile_y[%0d]", i), 32'(cy_log[i]), 32'(i / 3));
        end

        // Empty frame
        ws0 = ws_count;
        run_frame(32'h4000_0000, 16'h0100, 0, 3, 1, 1, 1, 1, 0, 1'b0, 1'b0, nr, dl);
        check("empty frame_start->done", 32'(dl), 32'd2);
        check("empty writer_start count", 32'(ws_count - ws0), 32'd0);

        // Backpressure on writer_flushed
        run_frame(32'h5000_0000, 16'h0200, 2, 1, 1, 3, 2, 4, 100, 1'b0, 1'b0, nr, dl);
        check("backpressure flushed->done latency", 32'(dl), 32'd1);
        check("backpressure tile_ready count", 32'(nr), 32'd2);

        // frame_start poke while busy, then reset mid-drain of the second tile
        fb_base = 32'h3000_0100; fb_stride = 16'h0400; tiles_x = CW'(2); tiles_y = CW'(1);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tile_valid = 1'b1;
            wait_out(0, 50, "rst-test writer_start", n);
            tile_valid = 1'b0;
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
            writer_reading = 1'b1;
            writer_flushed = 1'b0;
            repeat (4) step();
            if (k == 0) begin
                writer_reading = 1'b0;
                wait_out(1, 10, "rst-test tile_ready", n);
            end
        end
        check("pre-reset tile_x", 32'(tile_x), 32'd1);
        gpu_rst = 1'b1;
        step();
        gpu_rst = 1'b0;
        writer_reading = 1'b0;
        writer_flushed = 1'b1;
        check("post-reset busy", 32'(busy), 32'd0);
        check("post-reset frame_done", 32'(frame_done), 32'd0);
        check("post-reset tile_ready", 32'(tile_ready), 32'd0);
        check("post-reset writer_start", 32'(writer_start), 32'd0);
        check("post-reset tile_x", 32'(tile_x), 32'd0);
        check("post-reset tile_y", 32'(tile_y), 32'd0);
        check("post-reset writer_addr", writer_addr, 32'd0);
        check("post-reset writer_stride", 32'(writer_stride), 32'd0);
        fd_seen = 0;
        repeat (20) begin
            step();
            if (frame_done) fd_seen++;
        end
        check("no frame_done after reset", 32'(fd_seen), 32'd0);

`ifdef TILE_SCHED_PERF_EN
        run_frame(32'h6000_0000, 16'h0100, 2, 1, 10, 10, 3, 3, 1, 1'b0, 1'b0, nr, dl);
        check("perf_wait_cycles 2x1 delayed", perf_wait_cycles, 32'd20);
`endif

        // Randomized frames, including address wrap near 2^32
        for (int it = 0; it < 12; it++) begin
            int tx, ty;
            tx = int'($urandom_range(4, 0));
            ty = int'($urandom_range(3, 0));
            rbase = (it % 4 == 3) ? 32'hFFFF_FF80 : $urandom;
            run_frame(rbase, 16'($urandom), tx, ty, 1, 8, 1, 12, int'($urandom_range(6, 0)),
                      (it % 3 == 1), (it % 2 == 0), nr, dl);
            if (tx * ty == 0) begin
                check("rand empty latency", 32'(dl), 32'd2);
            end else begin
                check("rand tile_ready count", 32'(nr), 32'(tx * ty));
                check("rand flushed->done latency", 32'(dl), 32'd1);
            end
        end

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
